// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between N requesters (round-robin with
// optional fixed priority for requester 0) and routes in-order read data back by tag.
module sdram_arbiter #(
    parameter int N     = 4,
    parameter int AW    = 24,
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int PRIO0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             req_valid,
    input  logic [N-1:0]             req_we,
    input  logic [N*AW-1:0]          req_addr,
    input  logic [N*DW-1:0]          req_wdata,
    output logic [N-1:0]             req_ready,
    output logic [N-1:0]             rd_valid,
    output logic [DW-1:0]            rd_data,
    output logic                     mem_valid,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [DW-1:0]            mem_rdata,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] src_p1;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic          grant_rr;
    logic [N-1:0]  eligible;
    logic          slot_free;
    logic          rd_room;
    logic          push;
    logic          pop;

    logic [IW-1:0] tag_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    endfunction

    // A read waiting in the output slot already holds a tag reservation.
    assign outstanding = fifo_cnt + CW'(mem_valid & ~mem_we);
    assign rd_room     = outstanding < CW'(DEPTH);
    assign slot_free   = ~mem_valid | mem_ready;
    assign eligible    = req_valid & (req_we | {N{rd_room}});
    assign push        = mem_valid & mem_ready & ~mem_we;
    assign pop         = mem_rvalid & (fifo_cnt != '0);

    always_comb begin
        grant_any = 1'b0;
        grant_rr  = 1'b0;
        grant_idx = '0;
        if (slot_free && !reset) begin
            if (PRIO0 != 0 && eligible[0]) begin
                grant_any = 1'b1;
            end else begin
                // Descending scan so the nearest eligible index after ptr wins.
                for (int k = N - 1; k >= 0; k--) begin
                    if (eligible[wrap_idx(ptr, k)]) begin
                        grant_any = 1'b1;
                        grant_rr  = 1'b1;
                        grant_idx = wrap_idx(ptr, k);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_idx] = 1'b1;
    end

    // Stage p1: registered command slot, tag FIFO bookkeeping, response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            src_p1    <= '0;
            ptr       <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            if (grant_any) begin
                mem_valid <= 1'b1;
                mem_we    <= req_we[grant_idx];
                mem_addr  <= req_addr[grant_idx*AW +: AW];
                mem_wdata <= req_wdata[grant_idx*DW +: DW];
                src_p1    <= grant_idx;
                if (grant_rr) ptr <= next_idx(grant_idx);
            end else if (mem_ready) begin
                mem_valid <= 1'b0;
            end

            if (push) wr_ptr <= wr_ptr + PW'(1);

            rd_valid <= '0;
            if (pop) begin
                rd_valid <= N'(1) << tag_mem[rd_ptr];
                rd_data  <= mem_rdata;
                rd_ptr   <= rd_ptr + PW'(1);
            end

            if (mem_rvalid && fifo_cnt == '0) err <= 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= src_p1;
    end

endmodule
